// File: rtl/obuft_gtlp_tx_ctrl.sv
// Serial frame transmitter that drives a GTL+ tri-state output buffer (O_I data, O_T high-Z control).
// Optional even-parity bit between data and stop: define OBUFT_GTLP_TX_PARITY_EN.
module obuft_gtlp_tx_ctrl #(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 4,
  parameter int TURN    = 2
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             O_I,
  output logic             O_T,
  output logic             BUSY
);

  localparam int CW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BMAX = (WIDTH > TURN) ? WIDTH : TURN;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] TURN_LAST = BW'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_TURN
  } state_t;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] shiftQ, shiftD;
  logic [CW-1:0]    cycQ, cycD;
  logic [BW-1:0]    bitQ, bitD;
  logic             oIQ, oID;
  logic             oTQ, oTD;
  logic             busyQ, busyD;
  logic             bitEnd;
`ifdef OBUFT_GTLP_TX_PARITY_EN
  logic             parQ, parD;
`endif

  assign DREADY = (stateQ == S_IDLE) & ~CLR;
  assign bitEnd = (cycQ == CYC_LAST);
  assign O_I    = oIQ;
  assign O_T    = oTQ;
  assign BUSY   = busyQ;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      stateQ <= S_IDLE;
      shiftQ <= '0;
      cycQ   <= '0;
      bitQ   <= '0;
      oIQ    <= 1'b0;
      oTQ    <= 1'b1;
      busyQ  <= 1'b0;
`ifdef OBUFT_GTLP_TX_PARITY_EN
      parQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      shiftQ <= shiftD;
      cycQ   <= cycD;
      bitQ   <= bitD;
      oIQ    <= oID;
      oTQ    <= oTD;
      busyQ  <= busyD;
`ifdef OBUFT_GTLP_TX_PARITY_EN
      parQ   <= parD;
`endif
    end
  end

  // Outputs are registered from the next state so the line follows the state with no extra lag.
  always_comb begin
    stateD = stateQ;
    shiftD = shiftQ;
    cycD   = cycQ;
    bitD   = bitQ;
`ifdef OBUFT_GTLP_TX_PARITY_EN
    parD   = parQ;
`endif
    if (stateQ != S_IDLE) begin
      cycD = bitEnd ? '0 : cycQ + CW'(1);
    end
    case (stateQ)
      S_IDLE: begin
        if (DVALID && DREADY) begin
          stateD = S_START;
          shiftD = DIN;
          cycD   = '0;
          bitD   = '0;
`ifdef OBUFT_GTLP_TX_PARITY_EN
          parD   = ^DIN;
`endif
        end
      end
      S_START: begin
        if (bitEnd) stateD = S_DATA;
      end
      S_DATA: begin
        if (bitEnd) begin
          shiftD = shiftQ << 1;
          if (bitQ == DATA_LAST) begin
            bitD = '0;
`ifdef OBUFT_GTLP_TX_PARITY_EN
            stateD = S_PARITY;
`else
            stateD = S_STOP;
`endif
          end else begin
            bitD = bitQ + BW'(1);
          end
        end
      end
`ifdef OBUFT_GTLP_TX_PARITY_EN
      S_PARITY: begin
        if (bitEnd) stateD = S_STOP;
      end
`endif
      S_STOP: begin
        if (bitEnd) begin
          bitD   = '0;
          stateD = (TURN == 0) ? S_IDLE : S_TURN;
        end
      end
      S_TURN: begin
        if (bitEnd) begin
          if (bitQ == TURN_LAST) begin
            bitD   = '0;
            stateD = S_IDLE;
          end else begin
            bitD = bitQ + BW'(1);
          end
        end
      end
      default: stateD = S_IDLE;
    endcase
  end

  always_comb begin
    oTD   = (stateD == S_IDLE) || (stateD == S_TURN);
    busyD = (stateD != S_IDLE);
    oID   = 1'b0;
    case (stateD)
      S_DATA:   oID = shiftD[WIDTH-1];
`ifdef OBUFT_GTLP_TX_PARITY_EN
      S_PARITY: oID = parD;
`endif
      S_STOP:   oID = 1'b1;
      default:  oID = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_obuft_gtlp_tx_ctrl.sv
// Directed bench for obuft_gtlp_tx_ctrl: framing, turnaround, back-to-back, async clear, BIT_DIV=1,
// parity (when OBUFT_GTLP_TX_PARITY_EN is defined) and a random-word scoreboard.
module tb_obuft_gtlp_tx_ctrl;

`ifdef OBUFT_GTLP_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic PAR_EN = 1'b1;
`else
  localparam int NB = 10;
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int DIV = 4;
  localparam int TRN = 2;
  localparam int P   = (NB + TRN) * DIV + 1;

  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] dinA = '0, dinB = '0;
  logic       dvalidA = 1'b0, dvalidB = 1'b0;
  logic       dreadyA, oIA, oTA, busyA;
  logic       dreadyB, oIB, oTB, busyB;

  int checkCount = 0;
  int passCount  = 0;

  logic oiLog [0:127];
  logic otLog [0:127];
  logic busyLog [0:127];
  logic rdyLog [0:127];
  logic [7:0] expQ [$];

  obuft_gtlp_tx_ctrl #(.WIDTH(8), .BIT_DIV(DIV), .TURN(TRN)) dutA (
    .C(C), .CLR(CLR), .DIN(dinA), .DVALID(dvalidA),
    .DREADY(dreadyA), .O_I(oIA), .O_T(oTA), .BUSY(busyA)
  );

  obuft_gtlp_tx_ctrl #(.WIDTH(8), .BIT_DIV(1), .TURN(0)) dutB (
    .C(C), .CLR(CLR), .DIN(dinB), .DVALID(dvalidB),
    .DREADY(dreadyB), .O_I(oIB), .O_T(oTB), .BUSY(busyB)
  );

  always #5 C = ~C;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  // Called at a negedge with dutA idle; returns at the first negedge after the accept edge.
  task automatic applyStimulus(input logic [7:0] word);
    dinA = word;
    dvalidA = 1'b1;
    @(posedge C);
    @(negedge C);
    dvalidA = 1'b0;
  endtask

  task automatic captureA(input int n);
    for (int j = 0; j < n; j++) begin
      oiLog[j] = oIA; otLog[j] = oTA; busyLog[j] = busyA; rdyLog[j] = dreadyA;
      @(negedge C);
    end
  endtask

  function automatic logic [7:0] decodeA(input int off);
    logic [7:0] w;
    for (int b = 1; b <= 8; b++) w[8-b] = oiLog[off + b*DIV + 2];
    return w;
  endfunction

  task automatic runDriver();
    int gap, wait_cnt;
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) @(negedge C);
      dinA = 8'($urandom_range(0, 255));
      expQ.push_back(dinA);
      dvalidA = 1'b1;
      wait_cnt = 0;
      while (!dreadyA && wait_cnt < 200) begin
        @(negedge C);
        dinA = 8'($urandom_range(0, 255)) & 8'h00 | dinA;
        wait_cnt++;
      end
      if (wait_cnt >= 200) begin
        checkOutput("drvTimeout", wait_cnt, 0);
        dvalidA = 1'b0;
        return;
      end
      @(posedge C);
      @(negedge C);
      dvalidA = 1'b0;
      dinA = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic runMonitor();
    int frames = 0, budget = 0, lowCnt;
    logic fo [0:63];
    logic [7:0] w, expW;
    while (frames < 200 && budget < 30000) begin
      if (oTA == 1'b0) begin
        lowCnt = 0;
        for (int k = 0; k < NB*DIV; k++) begin
          fo[k] = oIA;
          if (oTA == 1'b0) lowCnt++;
          @(negedge C);
          budget++;
        end
        checkOutput("sbLowLen", lowCnt, NB*DIV);
        checkOutput("sbRelease", oTA, 1'b1);
        checkOutput("sbStart", fo[2], 1'b0);
        checkOutput("sbStop", fo[(NB-1)*DIV + 2], 1'b1);
        for (int b = 1; b <= 8; b++) w[8-b] = fo[b*DIV + 2];
        if (expQ.size() == 0) begin
          checkOutput("sbUnexpected", w, 8'h00 ^ ~w);
        end else begin
          expW = expQ.pop_front();
          checkOutput("sbWord", w, expW);
          if (PAR_EN) checkOutput("sbParity", fo[9*DIV + 2], ^expW);
        end
        frames++;
      end else begin
        @(negedge C);
        budget++;
      end
    end
    checkOutput("sbFrames", frames, 200);
  endtask

  logic [0:10] seqA5;
  int cnt;
  logic expBit;

  initial begin
    seqA5 = PAR_EN ? 11'b01010010101 : 11'b01010010110;
    // Reset state while CLR is held.
    repeat (2) @(negedge C);
    checkOutput("rstOT", oTA, 1'b1);
    checkOutput("rstOI", oIA, 1'b0);
    checkOutput("rstBusy", busyA, 1'b0);
    checkOutput("rstReady", dreadyA, 1'b0);
    CLR = 1'b0;
    @(negedge C);
    checkOutput("readyAfterRst", dreadyA, 1'b1);

    // Asynchronous clear in the middle of data bit 2 of 0xA5 (a '1' on the line).
    applyStimulus(8'hA5);
    repeat (12) @(negedge C);
    checkOutput("preClrOI", oIA, 1'b1);
    #2 CLR = 1'b1;
    #1;
    checkOutput("clrOT", oTA, 1'b1);
    checkOutput("clrOI", oIA, 1'b0);
    checkOutput("clrBusy", busyA, 1'b0);
    @(negedge C);
    CLR = 1'b0;
    @(negedge C);
    checkOutput("clrReady", dreadyA, 1'b1);
    checkOutput("clrBusyAfter", busyA, 1'b0);
    repeat (8) @(negedge C);
    checkOutput("clrDiscard", oTA, 1'b1);

    // Single 0xA5 frame.
    applyStimulus(8'hA5);
    captureA(60);
    for (int b = 0; b < NB; b++)
      checkOutput($sformatf("a5bit%0d", b),
                  {oiLog[b*DIV], oiLog[b*DIV+1], oiLog[b*DIV+2], oiLog[b*DIV+3]}, {4{seqA5[b]}});
    cnt = 0;
    for (int j = 0; j < 60; j++) if (!otLog[j]) cnt++;
    checkOutput("a5LowCount", cnt, NB*DIV);
    checkOutput("a5LastLow", otLog[NB*DIV-1], 1'b0);
    checkOutput("a5TurnHigh", {otLog[NB*DIV], otLog[NB*DIV+7]}, 2'b11);
    cnt = 0;
    for (int j = 0; j < 60; j++) if (busyLog[j]) cnt++;
    checkOutput("a5BusyCount", cnt, (NB+TRN)*DIV);
    checkOutput("a5BusyEnd", {busyLog[(NB+TRN)*DIV-1], busyLog[(NB+TRN)*DIV]}, 2'b10);
    cnt = 0;
    for (int j = NB*DIV; j < 60; j++) if (oiLog[j]) cnt++;
    checkOutput("a5TurnOI", cnt, 0);

    // Held DVALID: 0x3C then 0xC3 (DIN changes mid-frame).
    dinA = 8'h3C;
    dvalidA = 1'b1;
    @(posedge C);
    @(negedge C);
    for (int j = 0; j < 120; j++) begin
      oiLog[j] = oIA; otLog[j] = oTA; busyLog[j] = busyA; rdyLog[j] = dreadyA;
      if (j == 10) dinA = 8'hC3;
      if (j == P) dvalidA = 1'b0;
      @(negedge C);
    end
    cnt = 0;
    for (int j = 0; j < P-1; j++) if (rdyLog[j]) cnt++;
    checkOutput("b2bReadyLow", cnt, 0);
    checkOutput("b2bIdleCycle", {rdyLog[P-1], otLog[P-1], busyLog[P-1]}, 3'b110);
    checkOutput("b2bSecondStart", otLog[P], 1'b0);
    checkOutput("b2bWord1", decodeA(0), 8'h3C);
    checkOutput("b2bWord2", decodeA(P), 8'hC3);
    cnt = 0;
    for (int j = 2*P-1; j < 120; j++) if (!otLog[j]) cnt++;
    checkOutput("b2bNoThird", cnt, 0);

    // BIT_DIV=1, TURN=0 with 0xFF.
    dinB = 8'hFF;
    dvalidB = 1'b1;
    @(posedge C);
    @(negedge C);
    dvalidB = 1'b0;
    for (int j = 0; j < 15; j++) begin
      oiLog[j] = oIB; otLog[j] = oTB; busyLog[j] = busyB; rdyLog[j] = dreadyB;
      @(negedge C);
    end
    cnt = 0;
    for (int j = 0; j < 15; j++) if (!otLog[j]) cnt++;
    checkOutput("div1LowCount", cnt, NB);
    checkOutput("div1Edges", {otLog[NB-1], otLog[NB]}, 2'b01);
    for (int j = 0; j < NB; j++) begin
      expBit = (j == 0) ? 1'b0 : (PAR_EN && j == 9) ? 1'b0 : 1'b1;
      checkOutput($sformatf("div1bit%0d", j), oiLog[j], expBit);
    end
    checkOutput("div1Idle", {busyLog[NB-1], busyLog[NB], rdyLog[NB]}, 3'b101);

`ifdef OBUFT_GTLP_TX_PARITY_EN
    applyStimulus(8'h07);
    captureA(P + 4);
    checkOutput("par07", oiLog[9*DIV+2], 1'b1);
    cnt = 0;
    for (int j = 0; j < P + 4; j++) if (!otLog[j]) cnt++;
    checkOutput("parLen", cnt, 11*DIV);
    applyStimulus(8'h03);
    captureA(P + 4);
    checkOutput("par03", oiLog[9*DIV+2], 1'b0);
`endif

    fork
      runDriver();
      runMonitor();
    join
    checkOutput("sbQueueEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
